// File: rtl/mda_pkg.sv
`default_nettype none
// ============================================================================
// Module : mda_pkg
// Brief  : Shared constants, control codes, FSM state type and the
//          physical-row wrap function for the MDA text path. The chrram
//          read side uses add_mod_row so both sides wrap identically.
// Rev    : 1.0 - initial release
// ============================================================================
package mda_pkg;

  localparam int COLS = 80;
  localparam int ROWS = 25;

  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_FF    = 8'h0C;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_INIT_CLR = 2'd0,
    ST_IDLE     = 2'd1,
    ST_LINE_CLR = 2'd2,
    ST_SCR_CLR  = 2'd3
  } state_t;

  // (a + b) mod rows for a, b < rows, written as a compare-and-subtract so no
  // intermediate ever needs more than 5 bits.
  function automatic logic [4:0] add_mod_row(input logic [4:0] a,
                                             input logic [4:0] b,
                                             input logic [4:0] rows);
    if (a >= (rows - b)) return a - (rows - b);
    else                 return a + b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mda_clear_seq.sv
`default_nettype none
// ============================================================================
// Module : mda_clear_seq
// Brief  : Column/row sweep counter used for screen and line clears.
//          start loads (start_col, start_row) and selects single-row or
//          full-screen mode; step advances one cell; last flags the final
//          cell of the sweep.
// Ports  : clk, rst (async, active-high)
//          start, full, start_col, start_row, step  - control
//          col, row                                 - current cell
//          last                                     - current cell is final
// Rev    : 1.0 - initial release
// ============================================================================
module mda_clear_seq #(
  parameter int COLS = mda_pkg::COLS,
  parameter int ROWS = mda_pkg::ROWS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       full,
  input  logic [6:0] start_col,
  input  logic [4:0] start_row,
  input  logic       step,
  output logic [6:0] col,
  output logic [4:0] row,
  output logic       last
);

  localparam logic [6:0] C_LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] C_LAST_ROW = 5'(ROWS - 1);

  logic r_full;

  // Reset leaves the counter at (0,0) in full mode so the power-up clear
  // needs no explicit start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col    <= 7'd0;
      row    <= 5'd0;
      r_full <= 1'b1;
    end else if (start) begin
      col    <= start_col;
      row    <= start_row;
      r_full <= full;
    end else if (step) begin
      if (col == C_LAST_COL) begin
        col <= 7'd0;
        row <= (row == C_LAST_ROW) ? 5'd0 : row + 5'd1;
      end else begin
        col <= col + 7'd1;
      end
    end
  end

  assign last = (col == C_LAST_COL) && (!r_full || (row == C_LAST_ROW));

endmodule
`default_nettype wire

// File: rtl/mda_text_writer.sv
`default_nettype none
// ============================================================================
// Module : mda_text_writer
// Brief  : Teletype front end for the MDA character/attribute RAM. Accepts
//          bytes on a valid/ready handshake, writes printable codes at the
//          cursor, handles CR/LF/BS/FF, scrolls with a hardware row offset
//          and clears the new bottom line (or the whole screen) by bursts.
// Ports  : clk, rst (async, active-high)
//          in_valid/in_data/in_attr/in_ready         - byte stream input
//          wr_en/wr_col/wr_row/wr_code/wr_attr       - RAM write port
//          cur_col/cur_row                           - logical cursor
//          row_offset                                - physical row of line 0
// Rev    : 1.0 - initial release
// ============================================================================
module mda_text_writer #(
  parameter int         COLS       = mda_pkg::COLS,
  parameter int         ROWS       = mda_pkg::ROWS,
  parameter logic [7:0] CLEAR_ATTR = 8'h07
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic [7:0] in_attr,
  output logic       in_ready,
  output logic       wr_en,
  output logic [6:0] wr_col,
  output logic [4:0] wr_row,
  output logic [7:0] wr_code,
  output logic [7:0] wr_attr,
  output logic [6:0] cur_col,
  output logic [4:0] cur_row,
  output logic [4:0] row_offset
);

  import mda_pkg::*;

  localparam logic [6:0] C_LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] C_LAST_ROW = 5'(ROWS - 1);
  localparam logic [4:0] C_ROWS     = 5'(ROWS);

  state_t     r_state;

  logic       w_accept;
  logic       w_is_ctrl;
  logic       w_wrap;
  logic       w_newline;
  logic       w_scroll;
  logic       w_seq_start;
  logic       w_seq_full;
  logic       w_seq_step;
  logic       w_seq_last;
  logic [6:0] w_seq_start_col;
  logic [6:0] w_seq_col;
  logic [4:0] w_seq_start_row;
  logic [4:0] w_seq_row;
  logic [4:0] w_phys_row;
  logic [4:0] w_next_offset;

  always_comb begin
    w_accept        = (r_state == ST_IDLE) && in_valid && in_ready;
    w_is_ctrl       = (in_data == CHR_CR) || (in_data == CHR_LF) ||
                      (in_data == CHR_BS) || (in_data == CHR_FF);
    w_wrap          = !w_is_ctrl && (cur_col == C_LAST_COL);
    w_newline       = w_accept && ((in_data == CHR_LF) || w_wrap);
    w_scroll        = w_newline && (cur_row == C_LAST_ROW);
    w_seq_start     = w_scroll || (w_accept && (in_data == CHR_FF));
    w_seq_full      = (in_data == CHR_FF);
    w_seq_start_row = w_seq_full ? 5'd0 : row_offset;
    // LF and FF emit their first clear cell on the accept edge, so the sweep
    // resumes at column 1. A wrapping printable spends that edge on its own
    // character, so its line clear starts at column 0.
    w_seq_start_col = w_wrap ? 7'd0 : 7'd1;
    w_seq_step      = (r_state != ST_IDLE);
    w_phys_row      = add_mod_row(cur_row, row_offset, C_ROWS);
    w_next_offset   = (row_offset == C_LAST_ROW) ? 5'd0 : row_offset + 5'd1;
  end

  mda_clear_seq #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (w_seq_start),
    .full      (w_seq_full),
    .start_col (w_seq_start_col),
    .start_row (w_seq_start_row),
    .step      (w_seq_step),
    .col       (w_seq_col),
    .row       (w_seq_row),
    .last      (w_seq_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INIT_CLR;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_col     <= 7'd0;
      wr_row     <= 5'd0;
      wr_code    <= 8'd0;
      wr_attr    <= 8'd0;
      cur_col    <= 7'd0;
      cur_row    <= 5'd0;
      row_offset <= 5'd0;
    end else begin
      wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // in_ready rises one cycle after a clear finishes.
          in_ready <= 1'b1;
          if (w_accept) begin
            case (in_data)
              CHR_CR: cur_col <= 7'd0;
              CHR_BS: begin
                if (cur_col != 7'd0) cur_col <= cur_col - 7'd1;
              end
              CHR_LF: ;
              CHR_FF: begin
                row_offset <= 5'd0;
                cur_col    <= 7'd0;
                cur_row    <= 5'd0;
                wr_en      <= 1'b1;
                wr_col     <= 7'd0;
                wr_row     <= 5'd0;
                wr_code    <= CHR_SPACE;
                wr_attr    <= CLEAR_ATTR;
                in_ready   <= 1'b0;
                r_state    <= ST_SCR_CLR;
              end
              default: begin
                wr_en   <= 1'b1;
                wr_col  <= cur_col;
                wr_row  <= w_phys_row;
                wr_code <= in_data;
                wr_attr <= in_attr;
                cur_col <= w_wrap ? 7'd0 : cur_col + 7'd1;
              end
            endcase

            if (w_newline) begin
              if (!w_scroll) begin
                cur_row <= cur_row + 5'd1;
              end else begin
                // The old top line becomes the new bottom line.
                row_offset <= w_next_offset;
                in_ready   <= 1'b0;
                r_state    <= ST_LINE_CLR;
                if (in_data == CHR_LF) begin
                  wr_en   <= 1'b1;
                  wr_col  <= 7'd0;
                  wr_row  <= row_offset;
                  wr_code <= CHR_SPACE;
                  wr_attr <= CLEAR_ATTR;
                end
              end
            end
          end
        end

        default: begin
          // ST_INIT_CLR, ST_LINE_CLR, ST_SCR_CLR: one clear cell per cycle.
          in_ready <= 1'b0;
          wr_en    <= 1'b1;
          wr_col   <= w_seq_col;
          wr_row   <= w_seq_row;
          wr_code  <= CHR_SPACE;
          wr_attr  <= CLEAR_ATTR;
          if (w_seq_last) r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mda_text_writer.sv
`default_nettype none
// ============================================================================
// Module : tb_mda_text_writer
// Brief  : Directed self-checking bench for mda_text_writer.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mda_text_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic [7:0] in_attr = 8'd0;
  logic       in_ready;
  logic       wr_en;
  logic [6:0] wr_col;
  logic [4:0] wr_row;
  logic [7:0] wr_code;
  logic [7:0] wr_attr;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  logic [4:0] row_offset;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mda_text_writer #(
    .COLS       (80),
    .ROWS       (25),
    .CLEAR_ATTR (8'h07)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_attr    (in_attr),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_col     (wr_col),
    .wr_row     (wr_row),
    .wr_code    (wr_code),
    .wr_attr    (wr_attr),
    .cur_col    (cur_col),
    .cur_row    (cur_row),
    .row_offset (row_offset)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle transfer; returns at the cycle where its effect is visible.
  task automatic send(input logic [7:0] d, input logic [7:0] a);
    in_valid = 1'b1;
    in_data  = d;
    in_attr  = a;
    tick();
    in_valid = 1'b0;
  endtask

  // Entered on the cycle showing the first clear write.
  task automatic full_clear(input string tag);
    int errs;
    errs = 0;
    for (int k = 0; k < 2000; k++) begin
      if (wr_en !== 1'b1 || wr_col !== 7'(k % 80) || wr_row !== 5'(k / 80) ||
          wr_code !== 8'h20 || wr_attr !== 8'h07 || in_ready !== 1'b0)
        errs++;
      tick();
    end
    chk({tag, "_cells"}, 32'(errs), 32'd0);
    chk({tag, "_ready"}, 32'({in_ready, wr_en}), 32'(2'b10));
    chk({tag, "_cursor"}, 32'({row_offset, cur_row, cur_col}), 32'd0);
  endtask

  task automatic line_clear(input string tag, input logic [4:0] prow);
    int errs;
    errs = 0;
    for (int k = 0; k < 80; k++) begin
      if (wr_en !== 1'b1 || wr_col !== 7'(k) || wr_row !== prow ||
          wr_code !== 8'h20 || wr_attr !== 8'h07 || in_ready !== 1'b0)
        errs++;
      tick();
    end
    chk({tag, "_cells"}, 32'(errs), 32'd0);
    chk({tag, "_ready"}, 32'({in_ready, wr_en}), 32'(2'b10));
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ctrl", 32'({in_ready, wr_en, wr_col, wr_row}), 32'd0);
    chk("rst_data", 32'({wr_code, wr_attr}), 32'd0);
    chk("rst_cursor", 32'({row_offset, cur_row, cur_col}), 32'd0);

    // Power-up clear
    rst = 1'b0;
    tick();
    full_clear("init");

    // "AB" back-to-back
    in_valid = 1'b1; in_data = 8'h41; in_attr = 8'h0F;
    tick();
    chk("A_write", 32'({wr_en, wr_row, wr_col, wr_code, wr_attr}),
        32'({1'b1, 5'd0, 7'd0, 8'h41, 8'h0F}));
    in_data = 8'h42;
    tick();
    in_valid = 1'b0;
    chk("B_write", 32'({wr_en, wr_row, wr_col, wr_code, wr_attr}),
        32'({1'b1, 5'd0, 7'd1, 8'h42, 8'h0F}));
    tick();
    chk("AB_cursor", 32'({wr_en, cur_row, cur_col}), 32'({1'b0, 5'd0, 7'd2}));
    chk("hold_code", 32'({wr_code, wr_attr}), 32'({8'h42, 8'h0F}));

    // Move to (5,3)
    send(8'h0D, 8'h07);
    chk("cr_nowrite", 32'({wr_en, cur_col}), 32'({1'b0, 7'd0}));
    for (int i = 0; i < 3; i++) send(8'h0A, 8'h07);
    for (int i = 0; i < 5; i++) send(8'(8'h61 + i), 8'h07);
    chk("E_write", 32'({wr_en, wr_row, wr_col, wr_code}),
        32'({1'b1, 5'd3, 7'd4, 8'h65}));
    tick();
    chk("pos_5_3", 32'({cur_row, cur_col}), 32'({5'd3, 7'd5}));

    // BS, BS, CR, BS
    send(8'h08, 8'h07);
    chk("bs1", 32'({wr_en, cur_col}), 32'({1'b0, 7'd4}));
    send(8'h08, 8'h07);
    chk("bs2", 32'({wr_en, cur_col}), 32'({1'b0, 7'd3}));
    send(8'h0D, 8'h07);
    chk("cr", 32'({wr_en, cur_col}), 32'({1'b0, 7'd0}));
    send(8'h08, 8'h07);
    chk("bs_col0", 32'({wr_en, cur_row, cur_col}), 32'({1'b0, 5'd3, 7'd0}));

    // LF down to the bottom row, then scroll
    for (int i = 0; i < 21; i++) send(8'h0A, 8'h07);
    chk("at_bottom", 32'({in_ready, wr_en, row_offset, cur_row}),
        32'({1'b1, 1'b0, 5'd0, 5'd24}));
    send(8'h0A, 8'h07);
    chk("lf_scroll", 32'({row_offset, cur_row, in_ready}), 32'({5'd1, 5'd24, 1'b0}));
    line_clear("lf_clr", 5'd0);

    // Scroll until row_offset = 24
    for (int i = 0; i < 23; i++) begin
      send(8'h0A, 8'h07);
      repeat (80) tick();
    end
    chk("offset24", 32'({in_ready, row_offset, cur_row}), 32'({1'b1, 5'd24, 5'd24}));

    // Fill bottom line to column 79; logical 24 maps to physical 23
    send(8'h30, 8'h07);
    chk("bot_first", 32'({wr_en, wr_row, wr_col, wr_code}), 32'({1'b1, 5'd23, 7'd0, 8'h30}));
    for (int i = 1; i < 79; i++) send(8'(8'h30 + (i % 10)), 8'h07);
    tick();
    chk("pos_79_24", 32'({cur_row, cur_col}), 32'({5'd24, 7'd79}));

    // Printable at (79,24): write, then scroll and clear physical row 24
    send(8'h5A, 8'h70);
    chk("wrap_write", 32'({wr_en, wr_row, wr_col, wr_code, wr_attr}),
        32'({1'b1, 5'd23, 7'd79, 8'h5A, 8'h70}));
    chk("wrap_state", 32'({in_ready, row_offset, cur_row, cur_col}),
        32'({1'b0, 5'd0, 5'd24, 7'd0}));
    tick();
    line_clear("wrap_clr", 5'd24);

    // FF with nonzero cursor and offset
    send(8'h51, 8'h07);
    send(8'h0A, 8'h07);
    chk("pre_ff", 32'({row_offset, cur_col}), 32'({5'd1, 7'd1}));
    repeat (80) tick();
    send(8'h0C, 8'h07);
    full_clear("ff");

    // Reset in the middle of a scroll clear
    for (int i = 0; i < 24; i++) send(8'h0A, 8'h07);
    send(8'h0A, 8'h07);
    repeat (39) tick();
    chk("pre_rst_wr", 32'({wr_en, wr_row, wr_col}), 32'({1'b1, 5'd0, 7'd39}));
    rst = 1'b1;
    #1;
    chk("async_ctrl", 32'({in_ready, wr_en, wr_col, wr_row}), 32'd0);
    chk("async_data", 32'({wr_code, wr_attr, row_offset, cur_row, cur_col}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    full_clear("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
